// File: rtl/axis_frame_packer_if.sv
// Stream bundle shared by the narrow symbol side and the wide word side of axis_frame_packer.
// W is the data width: M on the symbol side, N on the word side.
interface axis_frame_packer_if #(
  parameter int W = 8
);
  logic [W-1:0] tdata;
  logic         tfirst;
  logic         tvalid;
  logic         tnext;

  modport master (output tdata, output tfirst, output tvalid, input tnext);
  modport slave  (input tdata, input tfirst, input tvalid, output tnext);
endinterface

// File: rtl/axis_frame_packer.sv
// axis_frame_packer: locks onto tfirst-marked LCM-bit frames of M-bit symbols and emits N-bit words.
// Define AXIS_FRAME_PACKER_ERR_CNT_EN to build the saturating 16-bit dropped-frame counter.
module axis_frame_packer #(
  parameter int N   = 8,
  parameter int M   = 3,
  parameter int LCM = 24
) (
  input  logic                       clk,
  input  logic                       rst,
  axis_frame_packer_if.slave         s_axis,
  axis_frame_packer_if.master        m_axis,
  output logic                       locked,
  output logic [15:0]                err_count
);
  localparam int KM = LCM / M;
  localparam int KN = LCM / N;
  localparam int WW = (KM > 2) ? $clog2(KM) : 1;
  localparam int RW = (KN > 2) ? $clog2(KN) : 1;

  generate
    if (KM < 2 || KN < 2 || (LCM % M) != 0 || (LCM % N) != 0) begin : g_bad_cfg
      $error("axis_frame_packer: LCM must be a multiple of N and M, with LCM/M >= 2 and LCM/N >= 2");
    end
  endgenerate

  typedef enum logic {HUNT, FILL} state_e;

  state_e         state_q, state_d;
  logic [WW-1:0]  widx_q, widx_d;
  logic [RW-1:0]  ridx_q, ridx_d;
  logic [1:0]     occ_q, occ_d;
  logic           wptr_q, wptr_d;
  logic           rptr_q, rptr_d;
  logic [1:0]     flag_q, flag_d;
  logic [LCM-1:0] page_q [2];
  logic [LCM-1:0] page_d [2];
  logic           s_take, m_take, commit, free_pg;
`ifdef AXIS_FRAME_PACKER_ERR_CNT_EN
  logic [15:0]    err_q, err_d;
`endif

  // Gated by rst so the handshake drops the instant reset is asserted.
  assign s_take = rst && s_axis.tvalid && (state_q == HUNT || occ_q != 2'd2);
  assign m_take = (occ_q != 2'd0) && m_axis.tnext;

  always_comb begin
    state_d = state_q;
    widx_d  = widx_q;
    ridx_d  = ridx_q;
    occ_d   = occ_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    flag_d  = flag_q;
    page_d  = page_q;
    commit  = 1'b0;
    free_pg = 1'b0;
`ifdef AXIS_FRAME_PACKER_ERR_CNT_EN
    err_d   = err_q;
`endif

    if (s_take) begin
      if (state_q == HUNT) begin
        if (s_axis.tfirst) begin
          page_d[wptr_q][LCM-1 -: M] = s_axis.tdata;
          flag_d[wptr_q] = 1'b1;
          widx_d         = WW'(1);
          state_d        = FILL;
        end
      end else if (widx_q == '0 || s_axis.tfirst) begin
        // A tfirst mid-frame drops the partial frame and restarts this page at symbol 0.
        page_d[wptr_q][LCM-1 -: M] = s_axis.tdata;
        flag_d[wptr_q] = s_axis.tfirst;
        widx_d         = WW'(1);
`ifdef AXIS_FRAME_PACKER_ERR_CNT_EN
        if (widx_q != '0 && err_q != 16'hFFFF) err_d = err_q + 16'd1;
`endif
      end else begin
        page_d[wptr_q][LCM-1-int'(widx_q)*M -: M] = s_axis.tdata;
        if (widx_q == WW'(KM-1)) begin
          commit = 1'b1;
          widx_d = '0;
          wptr_d = ~wptr_q;
        end else begin
          widx_d = widx_q + 1'b1;
        end
      end
    end

    if (m_take) begin
      if (ridx_q == RW'(KN-1)) begin
        ridx_d  = '0;
        rptr_d  = ~rptr_q;
        free_pg = 1'b1;
      end else begin
        ridx_d = ridx_q + 1'b1;
      end
    end

    case ({commit, free_pg})
      2'b10:   occ_d = occ_q + 2'd1;
      2'b01:   occ_d = occ_q - 2'd1;
      default: occ_d = occ_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= HUNT;
      widx_q  <= '0;
      ridx_q  <= '0;
      occ_q   <= '0;
      wptr_q  <= 1'b0;
      rptr_q  <= 1'b0;
      flag_q  <= '0;
      page_q  <= '{default: '0};
`ifdef AXIS_FRAME_PACKER_ERR_CNT_EN
      err_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      widx_q  <= widx_d;
      ridx_q  <= ridx_d;
      occ_q   <= occ_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      flag_q  <= flag_d;
      page_q  <= page_d;
`ifdef AXIS_FRAME_PACKER_ERR_CNT_EN
      err_q   <= err_d;
`endif
    end
  end

  assign s_axis.tnext  = s_take;
  assign m_axis.tvalid = (occ_q != 2'd0);
  assign m_axis.tdata  = page_q[rptr_q][LCM-1-int'(ridx_q)*N -: N];
  assign m_axis.tfirst = flag_q[rptr_q] && (ridx_q == '0);
  assign locked        = (state_q == FILL);
`ifdef AXIS_FRAME_PACKER_ERR_CNT_EN
  assign err_count     = err_q;
`else
  assign err_count     = 16'd0;
`endif
endmodule
